// File: rtl/fetch_unit.sv
// Instruction fetch stage: holds the PC, reads instruction memory over req/ack,
// and presents the latched instruction and its decoded fields to decode.
module fetch_unit #(
  parameter int unsigned        ADDR_W   = 16,
  parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  output logic [ADDR_W-1:0] imem_addr,
  output logic              imem_req,
  input  logic              imem_ack,
  input  logic [15:0]       imem_rdata,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  input  logic              stall,
  output logic              instr_valid,
  output logic [15:0]       instr,
  output logic [3:0]        opcode,
  output logic [3:0]        rd,
  output logic [3:0]        rs,
  output logic [3:0]        rt,
  output logic [7:0]        imm8,
  output logic [ADDR_W-1:0] pc_out,
  output logic [ADDR_W-1:0] pc_plus1,
  output logic              halted
);

  localparam int unsigned INSTR_W = 16;
  localparam logic [3:0]  OP_HALT = 4'b1111;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    VALID = 2'd2,
    HALT  = 2'd3
  } state_e;

  state_e               state_q, state_d;
  logic [ADDR_W-1:0]    pc_q, pc_d;
  logic [ADDR_W-1:0]    pc_out_q, pc_out_d;
  logic [INSTR_W-1:0]   instr_q, instr_d;

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      pc_q     <= RESET_PC;
      pc_out_q <= '0;
      instr_q  <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      pc_out_q <= pc_out_d;
      instr_q  <= instr_d;
    end
  end

  // Next-state logic; redirect always wins over ack/consume, except in HALT
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    pc_out_d = pc_out_q;
    instr_d  = instr_q;
    case (state_q)
      IDLE: begin
        state_d = REQ;
        if (redirect) pc_d = redirect_pc;
      end
      REQ: begin
        if (redirect) begin
          pc_d = redirect_pc;
        end else if (imem_ack) begin
          instr_d  = imem_rdata;
          pc_out_d = pc_q;
          pc_d     = pc_q + ADDR_W'(1);
          state_d  = VALID;
        end
      end
      VALID: begin
        if (redirect) begin
          pc_d    = redirect_pc;
          state_d = REQ;
        end else if (!stall) begin
          state_d = (instr_q[15:12] == OP_HALT) ? HALT : REQ;
        end
      end
      HALT: begin
        state_d = HALT;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign imem_addr   = pc_q;
  assign imem_req    = (state_q == REQ);
  assign instr_valid = (state_q == VALID);
  assign halted      = (state_q == HALT);

  assign instr    = instr_q;
  assign opcode   = instr_q[15:12];
  assign rd       = instr_q[11:8];
  assign rs       = instr_q[7:4];
  assign rt       = instr_q[3:0];
  assign imm8     = instr_q[7:0];
  assign pc_out   = pc_out_q;
  assign pc_plus1 = pc_out_q + ADDR_W'(1);

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: scoreboard of fetched words plus
// directed scenarios for stall, redirect, PC wrap, halt and reset.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] imem_addr;
  logic        imem_req;
  logic        imem_ack;
  logic [15:0] imem_rdata;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic        stall;
  logic        instr_valid;
  logic [15:0] instr;
  logic [3:0]  opcode, rd, rs, rt;
  logic [7:0]  imm8;
  logic [15:0] pc_out, pc_plus1;
  logic        halted;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [15:0] word;
    logic [15:0] pc;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        e;
  logic [15:0] exp_pc;

  always #5 clk = ~clk;

  fetch_unit #(.ADDR_W(16), .RESET_PC(16'h0000)) dut (
    .clk(clk), .rst(rst),
    .imem_addr(imem_addr), .imem_req(imem_req),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .redirect(redirect), .redirect_pc(redirect_pc), .stall(stall),
    .instr_valid(instr_valid), .instr(instr),
    .opcode(opcode), .rd(rd), .rs(rs), .rt(rt), .imm8(imm8),
    .pc_out(pc_out), .pc_plus1(pc_plus1), .halted(halted)
  );

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Waits (bounded) for a negedge with imem_req high
  task automatic wait_req(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (imem_req === 1'b1) begin
        ok = 1'b1;
        return;
      end
    end
  endtask

  // Acks the pending request with d and records what decode should see
  task automatic ack_now(input logic [15:0] d);
    imem_ack   = 1'b1;
    imem_rdata = d;
    exp_q.push_back('{word: d, pc: exp_pc});
    exp_pc = exp_pc + 16'd1;
    @(negedge clk);
    imem_ack   = 1'b0;
    imem_rdata = 16'h0000;
  endtask

  task automatic test_reset();
    rst = 1'b1; imem_ack = 1'b0; imem_rdata = '0;
    redirect = 1'b0; redirect_pc = '0; stall = 1'b0;
    exp_pc = 16'h0000;
    repeat (2) @(negedge clk);
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL rst_req got=%b exp=0", imem_req); end
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got=%b exp=0", instr_valid); end
    checks++; if (halted !== 1'b0) begin errors++; $display("FAIL rst_halted got=%b exp=0", halted); end
    checks++; if (instr !== 16'h0000) begin errors++; $display("FAIL rst_instr got=%h exp=0000", instr); end
    checks++; if (pc_out !== 16'h0000) begin errors++; $display("FAIL rst_pc_out got=%h exp=0000", pc_out); end
    checks++; if (pc_plus1 !== 16'h0001) begin errors++; $display("FAIL rst_pc_plus1 got=%h exp=0001", pc_plus1); end
    checks++; if (imem_addr !== 16'h0000) begin errors++; $display("FAIL rst_addr got=%h exp=0000", imem_addr); end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    bit ok;
    @(negedge clk);
    checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL basic_req_rise got=%b exp=1", imem_req); end
    checks++; if (imem_addr !== exp_pc) begin errors++; $display("FAIL basic_addr0 got=%h exp=%h", imem_addr, exp_pc); end
    ack_now(16'h0123);
    e = exp_q.pop_front();
    checks++; if (instr_valid !== 1'b1) begin errors++; $display("FAIL basic_valid0 got=%b exp=1", instr_valid); end
    checks++; if (instr !== e.word) begin errors++; $display("FAIL basic_instr0 got=%h exp=%h", instr, e.word); end
    checks++; if ({opcode, rd, rs, rt} !== 16'h0123) begin errors++; $display("FAIL basic_fields0 got=%h exp=0123", {opcode, rd, rs, rt}); end
    checks++; if (pc_out !== e.pc) begin errors++; $display("FAIL basic_pc_out0 got=%h exp=%h", pc_out, e.pc); end
    wait_req(ok);
    checks++; if (!ok) begin errors++; $display("FAIL basic_req_timeout got=0 exp=1"); end
    checks++; if (imem_addr !== 16'h0001) begin errors++; $display("FAIL basic_addr1 got=%h exp=0001", imem_addr); end
    ack_now(16'h8A05);
    e = exp_q.pop_front();
    checks++; if (instr_valid !== 1'b1) begin errors++; $display("FAIL basic_valid1 got=%b exp=1", instr_valid); end
    checks++; if (opcode !== 4'h8 || rd !== 4'hA || imm8 !== 8'h05) begin errors++; $display("FAIL basic_fields1 got=%h/%h/%h exp=8/a/05", opcode, rd, imm8); end
    checks++; if (pc_out !== e.pc) begin errors++; $display("FAIL basic_pc_out1 got=%h exp=%h", pc_out, e.pc); end
    checks++; if (pc_plus1 !== 16'h0002) begin errors++; $display("FAIL basic_pc_plus1 got=%h exp=0002", pc_plus1); end
  endtask

  task automatic test_stall();
    bit ok;
    wait_req(ok);
    checks++; if (!ok) begin errors++; $display("FAIL stall_req_timeout got=0 exp=1"); end
    ack_now(16'h2456);
    e = exp_q.pop_front();
    checks++; if (instr_valid !== 1'b1 || instr !== e.word) begin errors++; $display("FAIL stall_first got=%b/%h exp=1/%h", instr_valid, instr, e.word); end
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++; if (instr_valid !== 1'b1 || instr !== e.word || pc_out !== e.pc) begin errors++; $display("FAIL stall_hold%0d got=%b/%h/%h exp=1/%h/%h", i, instr_valid, instr, pc_out, e.word, e.pc); end
      checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL stall_noreq%0d got=%b exp=0", i, imem_req); end
      if (i == 2) stall = 1'b0;
    end
    @(negedge clk);
    checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL stall_req_after got=%b exp=1", imem_req); end
    checks++; if (imem_addr !== e.pc + 16'd1) begin errors++; $display("FAIL stall_next_addr got=%h exp=%h", imem_addr, e.pc + 16'd1); end
  endtask

  task automatic test_back_to_back();
    bit ok;
    logic [15:0] d;
    for (int i = 0; i < 4; i++) begin
      if (i == 0) ok = (imem_req === 1'b1);
      else wait_req(ok);
      checks++; if (!ok) begin errors++; $display("FAIL b2b_req_timeout%0d got=0 exp=1", i); end
      checks++; if (imem_addr !== exp_pc) begin errors++; $display("FAIL b2b_addr%0d got=%h exp=%h", i, imem_addr, exp_pc); end
      d = (i == 1) ? 16'hE123 : {4'($urandom_range(0, 13)), 12'($urandom)};
      ack_now(d);
      if (exp_q.size() == 0) begin
        checks++; errors++; $display("FAIL b2b_empty%0d got=empty exp=entry", i);
      end else begin
        e = exp_q.pop_front();
        checks++; if (instr_valid !== 1'b1 || instr !== e.word || pc_out !== e.pc) begin errors++; $display("FAIL b2b_instr%0d got=%b/%h/%h exp=1/%h/%h", i, instr_valid, instr, pc_out, e.word, e.pc); end
      end
    end
  endtask

  task automatic test_redirect_valid();
    bit ok;
    logic [15:0] held;
    wait_req(ok);
    checks++; if (!ok) begin errors++; $display("FAIL rdv_req_timeout got=0 exp=1"); end
    ack_now(16'h3333);
    e = exp_q.pop_front();
    held = e.word;
    checks++; if (instr_valid !== 1'b1 || instr !== held) begin errors++; $display("FAIL rdv_valid got=%b/%h exp=1/%h", instr_valid, instr, held); end
    redirect = 1'b1; redirect_pc = 16'h0040; exp_pc = 16'h0040;
    @(negedge clk);
    redirect = 1'b0;
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL rdv_drop got=%b exp=0", instr_valid); end
    checks++; if (imem_req !== 1'b1 || imem_addr !== 16'h0040) begin errors++; $display("FAIL rdv_target got=%b/%h exp=1/0040", imem_req, imem_addr); end
    checks++; if (halted !== 1'b0) begin errors++; $display("FAIL rdv_halted got=%b exp=0", halted); end
  endtask

  task automatic test_redirect_ack();
    imem_ack = 1'b1; imem_rdata = 16'hBEEF;
    redirect = 1'b1; redirect_pc = 16'h0080; exp_pc = 16'h0080;
    @(negedge clk);
    imem_ack = 1'b0; redirect = 1'b0;
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL rda_valid got=%b exp=0", instr_valid); end
    checks++; if (instr !== 16'h3333) begin errors++; $display("FAIL rda_instr got=%h exp=3333", instr); end
    checks++; if (imem_req !== 1'b1 || imem_addr !== 16'h0080) begin errors++; $display("FAIL rda_target got=%b/%h exp=1/0080", imem_req, imem_addr); end
    @(negedge clk);
    checks++; if (imem_req !== 1'b1 || imem_addr !== 16'h0080) begin errors++; $display("FAIL rda_wait_stable got=%b/%h exp=1/0080", imem_req, imem_addr); end
  endtask

  task automatic test_wrap();
    redirect = 1'b1; redirect_pc = 16'hFFFF; exp_pc = 16'hFFFF;
    @(negedge clk);
    redirect = 1'b0;
    checks++; if (imem_addr !== 16'hFFFF) begin errors++; $display("FAIL wrap_addr got=%h exp=ffff", imem_addr); end
    ack_now(16'hD300);
    e = exp_q.pop_front();
    checks++; if (pc_out !== e.pc || pc_plus1 !== 16'h0000) begin errors++; $display("FAIL wrap_pc got=%h/%h exp=%h/0000", pc_out, pc_plus1, e.pc); end
    checks++; if (opcode !== 4'hD || instr_valid !== 1'b1) begin errors++; $display("FAIL wrap_op got=%h/%b exp=d/1", opcode, instr_valid); end
    @(negedge clk);
    checks++; if (imem_req !== 1'b1 || imem_addr !== 16'h0000) begin errors++; $display("FAIL wrap_next got=%b/%h exp=1/0000", imem_req, imem_addr); end
  endtask

  task automatic test_halt();
    ack_now(16'hF000);
    e = exp_q.pop_front();
    checks++; if (instr_valid !== 1'b1 || opcode !== 4'hF) begin errors++; $display("FAIL halt_present got=%b/%h exp=1/f", instr_valid, opcode); end
    @(negedge clk);
    checks++; if (halted !== 1'b1 || imem_req !== 1'b0 || instr_valid !== 1'b0) begin errors++; $display("FAIL halt_enter got=%b/%b/%b exp=1/0/0", halted, imem_req, instr_valid); end
    redirect = 1'b1; redirect_pc = 16'h1234;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++; if (halted !== 1'b1 || imem_req !== 1'b0 || imem_addr !== 16'h0001) begin errors++; $display("FAIL halt_hold%0d got=%b/%b/%h exp=1/0/0001", i, halted, imem_req, imem_addr); end
    end
    redirect = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_pc = 16'h0000;
    checks++; if (halted !== 1'b0 || imem_addr !== 16'h0000) begin errors++; $display("FAIL halt_rst got=%b/%h exp=0/0000", halted, imem_addr); end
    @(negedge clk);
    checks++; if (imem_req !== 1'b1 || imem_addr !== 16'h0000) begin errors++; $display("FAIL halt_restart got=%b/%h exp=1/0000", imem_req, imem_addr); end
  endtask

  task automatic test_reset_midreq();
    redirect = 1'b1; redirect_pc = 16'h0555;
    @(negedge clk);
    redirect = 1'b0;
    imem_ack = 1'b1; imem_rdata = 16'hAAAA; rst = 1'b1;
    @(negedge clk);
    imem_ack = 1'b0; rst = 1'b0;
    exp_pc = 16'h0000;
    exp_q.delete();
    checks++; if (imem_req !== 1'b0 || instr_valid !== 1'b0 || halted !== 1'b0) begin errors++; $display("FAIL mrst_ctrl got=%b/%b/%b exp=0/0/0", imem_req, instr_valid, halted); end
    checks++; if (instr !== 16'h0000 || pc_out !== 16'h0000 || pc_plus1 !== 16'h0001) begin errors++; $display("FAIL mrst_data got=%h/%h/%h exp=0000/0000/0001", instr, pc_out, pc_plus1); end
    checks++; if (imem_addr !== 16'h0000) begin errors++; $display("FAIL mrst_addr got=%h exp=0000", imem_addr); end
    @(negedge clk);
    checks++; if (imem_req !== 1'b1 || imem_addr !== 16'h0000) begin errors++; $display("FAIL mrst_restart got=%b/%h exp=1/0000", imem_req, imem_addr); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_back_to_back();
    test_redirect_valid();
    test_redirect_ack();
    test_wrap();
    test_halt();
    test_reset_midreq();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction fetch stage feeding the control unit and register file. Holds the PC and issues word reads to instruction memory over a req/ack handshake. Latches each 16-bit instruction, splits it into opcode/rd/rs/rt/imm8 for decode, and holds it until decode accepts it. Accepts branch/jump redirects from execute (BRZ taken, JAL) and halts on opcode 4'b1111.

Parameters:
ADDR_W, 16, PC / instruction address width (word addressed)
RESET_PC, 16'h0000, PC value loaded on reset

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous active-high reset
imem_addr  output  ADDR_W  instruction memory word address; equals PC
imem_req  output  1  read request; high only in REQ state
imem_ack  input  1  memory returns imem_rdata this cycle
imem_rdata  input  16  instruction word, valid when imem_ack=1
redirect  input  1  load redirect_pc into PC and flush current instruction
redirect_pc  input  ADDR_W  branch/jump target
stall  input  1  decode cannot accept the presented instruction
instr_valid  output  1  instr and fields are valid for decode
instr  output  16  latched instruction word
opcode  output  4  instr[15:12]
rd  output  4  instr[11:8]
rs  output  4  instr[7:4]
rt  output  4  instr[3:0]
imm8  output  8  instr[7:0]
pc_out  output  ADDR_W  address of the presented instruction
pc_plus1  output  ADDR_W  pc_out+1 mod 2^ADDR_W (JAL link value)
halted  output  1  fetch stopped after a halt opcode was consumed

Behaviour:
- All state updates on rising clk. rst overrides everything, including mid-request and in HALT.
- Reset values: state=IDLE, PC=RESET_PC, instr=0, pc_out=0, instr_valid=0, imem_req=0, halted=0. Field outputs are therefore 0 and pc_plus1=1.
- Field outputs and pc_plus1 are combinational from the instr and pc_out registers.
- imem_addr=PC at all times. imem_req=(state==REQ). instr_valid=(state==VALID). halted=(state==HALT).
- IDLE: go to REQ unconditionally. Also apply redirect if asserted.
- REQ, checked in priority order:
  - redirect: PC<=redirect_pc, stay REQ. An imem_ack in the same cycle is discarded.
  - imem_ack: instr<=imem_rdata, pc_out<=PC, PC<=PC+1 (wraps FFFF->0000), go to VALID.
  - otherwise: hold; PC and address stay stable while waiting.
- VALID, checked in priority order:
  - redirect: PC<=redirect_pc, go to REQ. The instruction is dropped and counts as not consumed.
  - !stall and opcode==4'b1111: consumed, go to HALT.
  - !stall: consumed, go to REQ.
  - stall: hold; instr, pc_out and instr_valid stay unchanged.
- HALT: imem_req=0, instr_valid=0, redirect ignored. Only rst exits.
- Opcode 4'b1110 is delivered normally; it is not special to fetch.
- Latency: imem_ack in cycle N -> instr_valid in cycle N+1.
- Throughput: at most one instruction per 2 cycles (REQ + VALID).
- Consumption rule: an instruction is consumed on a cycle with instr_valid=1, stall=0 and redirect=0.
- Memory contract: the memory must tolerate imem_addr changing while imem_req is high (redirect during REQ).

Test Plan:
- Reset, then imem_ack=1 every REQ cycle with rdata=16'h0123 then 16'h8A05, stall=0:
  - imem_req rises 1 cycle after reset release; addr 0000 then 0001.
  - instr_valid pulses with opcode=0, rd=1, rs=2, rt=3, pc_out=0000, then opcode=8, rd=A, imm8=05, pc_out=0001.
- Present 16'h2456 with stall=1 for 3 cycles: instr_valid and instr held 4 cycles. imem_req stays 0 until the cycle after stall drops. Next fetch uses addr=pc_out+1.
- Redirect during VALID with redirect_pc=16'h0040: instr_valid drops next cycle and the instruction is never consumed. Next request has imem_addr=0040.
- Redirect to 16'h0080 in the same cycle as imem_ack: returned data discarded, instr unchanged, next request addr=0080.
- Wrap:
  - redirect to FFFF, ack rdata=16'hD300: pc_out=FFFF, pc_plus1=0000, next imem_addr=0000.
  - rdata=16'hF000 consumed: halted=1, no further imem_req, redirect ignored; rst returns PC to RESET_PC.
- Assert rst while in REQ with imem_ack pending: next cycle state IDLE, all outputs at reset values, PC=RESET_PC.
